// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser/debouncer with press, release and optional auto-repeat pulses
// Optional feature macro: BTN_DEBOUNCE_AUTO_REPEAT_EN (auto-repeat while held; o_repeat tied 0 otherwise).
module btn_debounce #(
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 500,
    parameter int REPEAT_MS   = 100
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ms_tick,
    input  logic i_btn_in,
    output logic o_btn_db,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 || LONG_MS < 2 || LONG_MS > 4095 ||
        REPEAT_MS < 1 || REPEAT_MS > LONG_MS) begin : g_bad_cfg
        $error("btn_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_btn_s;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_nxt;
    logic            r_btn_db;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    logic            w_btn_db_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_repeat_nxt;

    assign w_btn_s = r_sync2;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_LOW;
            r_db_cnt  <= '0;
            r_btn_db  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
            r_btn_db  <= w_btn_db_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    // A bounce in a WAIT state always wins over a coincident tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        case (r_state)
            S_LOW: begin
                if (w_btn_s) begin
                    w_state_nxt  = S_WAIT_HIGH;
                    w_db_cnt_nxt = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt = S_LOW;
                end else if (i_ms_tick) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_state_nxt = S_HIGH;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + DB_ONE;
                    end
                end
            end
            S_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt  = S_WAIT_LOW;
                    w_db_cnt_nxt = '0;
                end
            end
            S_WAIT_LOW: begin
                if (w_btn_s) begin
                    w_state_nxt = S_HIGH;
                end else if (i_ms_tick) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_state_nxt = S_LOW;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + DB_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt  = S_LOW;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_btn_db_nxt  = (w_state_nxt == S_HIGH) || (w_state_nxt == S_WAIT_LOW);
        w_press_nxt   = (r_state == S_WAIT_HIGH) && (w_state_nxt == S_HIGH);
        w_release_nxt = (r_state == S_WAIT_LOW) && (w_state_nxt == S_LOW);
    end

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int HD_W = $clog2(LONG_MS + 1);
    localparam logic [HD_W-1:0] HD_LAST   = HD_W'(LONG_MS - 1);
    localparam logic [HD_W-1:0] HD_RELOAD = HD_W'(LONG_MS - REPEAT_MS);
    localparam logic [HD_W-1:0] HD_ONE    = HD_W'(1);

    logic [HD_W-1:0] r_hold_cnt;
    logic            w_hold_run;

    // Hold time only advances in a steady HIGH; WAIT_LOW freezes it.
    assign w_hold_run   = (r_state == S_HIGH) && w_btn_s && i_ms_tick;
    assign w_repeat_nxt = w_hold_run && (r_hold_cnt == HD_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hold_cnt <= '0;
        end else if (w_press_nxt) begin
            r_hold_cnt <= '0;
        end else if (w_hold_run) begin
            r_hold_cnt <= (r_hold_cnt == HD_LAST) ? HD_RELOAD : r_hold_cnt + HD_ONE;
        end
    end
`else
    assign w_repeat_nxt = 1'b0;
`endif

    assign o_btn_db  = r_btn_db;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule
